lsu: RTL
========

# lsu

Load/store unit between the execute stage and the data memory port. Accepts one decoded load or store (opcode class, funct3, address, store data, rd) per transaction. Drives a valid/ready word-addressed memory bus with byte enables, extracts and sign/zero-extends load data, and returns a one-cycle writeback pulse. Misaligned or illegal-width accesses are rejected without touching memory.

## Interface
Parameters:
- XLEN, riscv_pkg::XLEN (32): data/address width; only 32 supported.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  1  execute offers a memory op
- req_ready_o  out  1  LSU can accept (high only in IDLE)
- req_is_store_i  in  1  1 = store (OP_STORE), 0 = load (OP_LOAD)
- req_f3_i  in  3  funct3 (F3_LOAD_*/F3_STORE_* encodings)
- req_addr_i  in  XLEN  effective byte address
- req_wdata_i  in  XLEN  store data (rs2)
- req_rd_i  in  5  load destination register
- mem_valid_o  out  1  memory request valid
- mem_ready_i  in  1  memory accepts request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  XLEN  word address, bits [1:0] always 0
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  XLEN  lane-replicated store data
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  XLEN  read word
- wb_valid_o  out  1  one-cycle load writeback pulse
- wb_rd_o  out  5  writeback register
- wb_data_o  out  XLEN  extended load result
- fault_o  out  1  one-cycle pulse: misaligned or illegal funct3
- busy_o  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE: req_ready_o=1. On req_valid_i, latch all request fields; classify.
  - Illegal: load f3 ∈ {011,110,111}; store f3 ≥ 011. Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0. On either, go to DONE with fault_o=1. No memory access, no writeback.
  - Otherwise go to REQ.
- REQ: mem_valid_o=1. mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o stay stable until mem_ready_i. On handshake: store goes to IDLE; load goes to RESP.
- RESP: wait for mem_rvalid_i, then register the result and go to DONE with wb_valid_o=1.
- DONE: lasts one cycle, during which the wb_valid_o or fault_o pulse is visible. Then go to IDLE.
- Byte enables:
  - SB/LB/LBU: 4'b0001<<addr[1:0].
  - SH/LH/LHU: 4'b0011<<addr[1:0].
  - W: 4'b1111.
- Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- Load extract: shift mem_rdata_i right by 8·addr[1:0]. Sign-extend LB/LH; zero-extend LBU/LHU; LW unchanged.
- Loads with rd=0 still access memory and pulse wb_valid_o with wb_rd_o=0. The register file discards the write.
- mem_rvalid_i outside RESP is ignored.

## Timing
- Reset values:
  - State IDLE.
  - mem_valid_o, mem_we_o, wb_valid_o, fault_o, busy_o = 0.
  - mem_addr_o, mem_be_o, mem_wdata_o, wb_rd_o, wb_data_o = 0.
- Accept at cycle 0. mem_valid_o is high from cycle 1.
  - Store, zero-wait memory: handshake at cycle 1, req_ready_o high at cycle 2.
  - Load, rvalid at cycle 2: wb_valid_o at cycle 3, req_ready_o at cycle 4.
- Fault: fault_o is high at cycle 1, req_ready_o high at cycle 2.
- Memory stalls (mem_ready_i low, rvalid late) extend REQ/RESP indefinitely with outputs held.
- rst in any state returns to IDLE next cycle. Any in-flight request is abandoned and the memory side is reset together with the LSU.
- No combinational path from mem_* inputs to mem_* outputs. req_ready_o is decoded from state only.

## Structure
- The LSU FSM states go in riscv_pkg as lsu_state_t.
- A packed lsu_req_t (is_store, f3, addr, wdata, rd) goes in riscv_pkg. The existing F3_LOAD_*/F3_STORE_* constants are reused unchanged.
- Sub-module lsu_align: combinational. It produces byte enables, replicated store data, the misaligned/illegal flag, and the extended load data from (is_store, f3, addr[1:0], wdata, rdata). It is verified standalone.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, mem_ready_i=1 → mem_addr 0x100, be 1111, wdata 0xDEADBEEF, we=1 for one cycle; no wb_valid_o.
- SB addr 0x103, wdata 0x000000A5 → be 1000, mem_wdata 0xA5A5A5A5, mem_addr 0x100.
- LB addr 0x102, rdata 0x0080FF00, rd=5 → wb_data 0xFFFFFF80, wb_rd 5. The same access as LBU → 0x00000080.
- LH addr 0x102, rdata 0x8001_0000 → wb_data 0xFFFF8001. LW addr 0x101 → fault_o pulse, mem_valid_o never asserted.
- Load with mem_ready_i low 3 cycles and rvalid 4 cycles later → address held stable throughout, single wb_valid_o pulse; a stray rvalid while in IDLE → no wb_valid_o.
- rst asserted while in RESP → next cycle IDLE, all outputs 0. A subsequent legal SW completes normally.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared core constants and types: data width, major opcodes,
//               load/store funct3 encodings, LSU state and request types.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN = 32;

    // Major opcodes of the memory instruction classes
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Load funct3 encodings
    localparam logic [2:0] F3_LOAD_LB  = 3'b000;
    localparam logic [2:0] F3_LOAD_LH  = 3'b001;
    localparam logic [2:0] F3_LOAD_LW  = 3'b010;
    localparam logic [2:0] F3_LOAD_LBU = 3'b100;
    localparam logic [2:0] F3_LOAD_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_STORE_SB = 3'b000;
    localparam logic [2:0] F3_STORE_SH = 3'b001;
    localparam logic [2:0] F3_STORE_SW = 3'b010;

    // Load/store unit sequencing states
    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_t;

    // One decoded memory operation as handed over by execute
    typedef struct packed {
        logic            is_store;
        logic [2:0]      f3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [4:0]      rd;
    } lsu_req_t;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane logic for the LSU: byte enables, store
//               data replication, access legality and load extension.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import riscv_pkg::*;
(
    input  logic            i_is_store,
    input  logic [2:0]      i_f3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic            o_fault,
    output logic [XLEN-1:0] o_rdata
);

    logic [XLEN-1:0] w_shift;
    logic            w_illegal;
    logic            w_misalign;

    // Legality: width encodings outside the supported set, or natural alignment broken
    always_comb begin
        w_illegal = 1'b0;
        if (i_is_store) begin
            w_illegal = (i_f3 > F3_STORE_SW);
        end else begin
            case (i_f3)
                F3_LOAD_LB, F3_LOAD_LH, F3_LOAD_LW,
                F3_LOAD_LBU, F3_LOAD_LHU: w_illegal = 1'b0;
                default:                  w_illegal = 1'b1;
            endcase
        end

        // Width is carried in f3[1:0] for both loads and stores
        case (i_f3[1:0])
            2'b01:   w_misalign = i_addr_lo[0];
            2'b10:   w_misalign = (i_addr_lo != 2'b00);
            default: w_misalign = 1'b0;
        endcase

        o_fault = w_illegal | w_misalign;
    end

    // Byte enables and lane-replicated store data by access width
    always_comb begin
        case (i_f3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be    = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then sign- or zero-extend
    always_comb begin
        w_shift = i_rdata >> {i_addr_lo, 3'b000};
        case (i_f3)
            F3_LOAD_LB:  o_rdata = {{(XLEN-8){w_shift[7]}}, w_shift[7:0]};
            F3_LOAD_LH:  o_rdata = {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
            F3_LOAD_LBU: o_rdata = {{(XLEN-8){1'b0}}, w_shift[7:0]};
            F3_LOAD_LHU: o_rdata = {{(XLEN-16){1'b0}}, w_shift[15:0]};
            default:     o_rdata = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Load/store unit between execute and a valid/ready word
//               addressed data memory port. One transaction at a time,
//               registered memory and writeback outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_is_store_i,
    input  logic [2:0]      req_f3_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic [4:0]      req_rd_i,

    output logic            mem_valid_o,
    input  logic            mem_ready_i,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,

    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,

    output logic            fault_o,
    output logic            busy_o
);

    lsu_state_t      r_state;
    lsu_req_t        r_req;

    logic            r_mem_valid;
    logic            r_mem_we;
    logic [3:0]      r_mem_be;
    logic [XLEN-1:0] r_mem_wdata;
    logic            r_wb_valid;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;
    logic            r_fault;

    lsu_req_t        w_in;
    logic            w_sel_is_store;
    logic [2:0]      w_sel_f3;
    logic [1:0]      w_sel_addr_lo;
    logic [XLEN-1:0] w_sel_wdata;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic            w_bad;
    logic [XLEN-1:0] w_rdata_ext;

    // Pack the incoming request; in IDLE the lane logic classifies the offer,
    // otherwise it works on the latched request (load extraction in RESP)
    always_comb begin
        w_in.is_store  = req_is_store_i;
        w_in.f3        = req_f3_i;
        w_in.addr      = req_addr_i;
        w_in.wdata     = req_wdata_i;
        w_in.rd        = req_rd_i;

        w_sel_is_store = (r_state == LSU_IDLE) ? w_in.is_store  : r_req.is_store;
        w_sel_f3       = (r_state == LSU_IDLE) ? w_in.f3        : r_req.f3;
        w_sel_addr_lo  = (r_state == LSU_IDLE) ? w_in.addr[1:0] : r_req.addr[1:0];
        w_sel_wdata    = (r_state == LSU_IDLE) ? w_in.wdata     : r_req.wdata;
    end

    lsu_align u_align (
        .i_is_store (w_sel_is_store),
        .i_f3       (w_sel_f3),
        .i_addr_lo  (w_sel_addr_lo),
        .i_wdata    (w_sel_wdata),
        .i_rdata    (mem_rdata_i),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_fault    (w_bad),
        .o_rdata    (w_rdata_ext)
    );

    // Transaction sequencer with all bus and writeback outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LSU_IDLE;
            r_req       <= '0;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= '0;
            r_fault     <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_fault    <= 1'b0;
            case (r_state)
                LSU_IDLE: begin
                    if (req_valid_i) begin
                        r_req <= w_in;
                        if (w_bad) begin
                            // Rejected accesses never reach the memory bus
                            r_fault <= 1'b1;
                            r_state <= LSU_DONE;
                        end else begin
                            r_mem_valid <= 1'b1;
                            r_mem_we    <= w_in.is_store;
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata;
                            r_state     <= LSU_REQ;
                        end
                    end
                end
                LSU_REQ: begin
                    if (mem_ready_i) begin
                        r_mem_valid <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_state     <= r_req.is_store ? LSU_IDLE : LSU_RESP;
                    end
                end
                LSU_RESP: begin
                    if (mem_rvalid_i) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_req.rd;
                        r_wb_data  <= w_rdata_ext;
                        r_state    <= LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    r_state <= LSU_IDLE;
                end
                default: begin
                    r_state <= LSU_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = (r_state == LSU_IDLE);
    assign busy_o      = (r_state != LSU_IDLE);
    assign mem_valid_o = r_mem_valid;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = {r_req.addr[XLEN-1:2], 2'b00};
    assign mem_be_o    = r_mem_be;
    assign mem_wdata_o = r_mem_wdata;
    assign wb_valid_o  = r_wb_valid;
    assign wb_rd_o     = r_wb_rd;
    assign wb_data_o   = r_wb_data;
    assign fault_o     = r_fault;

endmodule
`default_nettype wire
